// File: rtl/infer_pkg.sv
// Shared types and constants for the inference sequencer and its argmax tracker.
package infer_pkg;

  localparam int NUM_CLASSES    = 10;
  localparam int LOGIT_W        = 6;
  localparam int ADDR_W         = 4;
  localparam int TIMEOUT_CYCLES = 4095;
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1_RUN,
    S_L2_RUN,
    S_L2_RELEASE,
    S_SCAN,
    S_RESULT
  } state_e;

endpackage

// File: rtl/argmax_tracker.sv
// Running argmax over a stream of signed logits; ties keep the earliest index.
// Outputs already include the current sample so the caller can capture the final winner on the last scan cycle.
module argmax_tracker
  import infer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_first,
  input  logic               sample_en,
  input  logic [ADDR_W-1:0]  index,
  input  logic [LOGIT_W-1:0] data,
  output logic [ADDR_W-1:0]  best_idx,
  output logic [LOGIT_W-1:0] best_val
);

  logic [ADDR_W-1:0]  idx_q;
  logic [LOGIT_W-1:0] val_q;
  logic               take;

  // Strictly greater only, so an equal later logit never displaces an earlier one.
  always_comb begin
    take     = sample_en && (load_first || ($signed(data) > $signed(val_q)));
    best_idx = take ? index : idx_q;
    best_val = take ? data  : val_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      val_q <= '0;
    end else if (take) begin
      idx_q <= index;
      val_q <= data;
    end
  end

endmodule

// File: rtl/inference_sequencer.sv
// Runs one classification: layer 1, layer 2, then an argmax scan of layer 2's logits.
// Optional per-phase watchdog is compiled in with `define INFER_TIMEOUT_EN.
module inference_sequencer
  import infer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  output logic               busy,
  output logic               l1_start,
  input  logic               l1_done,
  output logic               l2_start,
  input  logic               l2_done,
  output logic [3:0]         l2_read_addr,
  input  logic [LOGIT_W-1:0] l2_read_data,
  output logic               result_valid,
  output logic [3:0]         result_class,
  output logic [LOGIT_W-1:0] result_logit,
  output logic               err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CLASSES - 1);

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               l1_start_q, l1_start_d;
  logic               l2_start_q, l2_start_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               rvalid_q, rvalid_d;
  logic [ADDR_W-1:0]  rclass_q, rclass_d;
  logic [LOGIT_W-1:0] rlogit_q, rlogit_d;

  logic               scan_en;
  logic               scan_first;
  logic [ADDR_W-1:0]  best_idx;
  logic [LOGIT_W-1:0] best_val;

  assign scan_en    = (state_q == S_SCAN);
  assign scan_first = scan_en && (addr_q == '0);

  argmax_tracker u_tracker (
    .clk        (clk),
    .rst        (rst),
    .load_first (scan_first),
    .sample_en  (scan_en),
    .index      (addr_q),
    .data       (l2_read_data),
    .best_idx   (best_idx),
    .best_val   (best_val)
  );

`ifdef INFER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             watched;
`endif

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    l1_start_d = 1'b0;
    l2_start_d = l2_start_q;
    addr_d     = '0;
    rvalid_d   = 1'b0;
    rclass_d   = rclass_q;
    rlogit_d   = rlogit_q;

    unique case (state_q)
      S_IDLE: begin
        busy_d     = 1'b0;
        l2_start_d = 1'b0;
        if (req) begin
          state_d    = S_L1_RUN;
          busy_d     = 1'b1;
          l1_start_d = 1'b1;
        end
      end
      S_L1_RUN: begin
        if (l1_done) begin
          state_d    = S_L2_RUN;
          l2_start_d = 1'b1;
        end
      end
      S_L2_RUN: begin
        l2_start_d = 1'b1;
        if (l2_done) begin
          state_d    = S_L2_RELEASE;
          l2_start_d = 1'b0;
        end
      end
      S_L2_RELEASE: begin
        l2_start_d = 1'b0;
        if (!l2_done) begin
          state_d = S_SCAN;
        end
      end
      // The last sample and the result capture happen on the same edge via the tracker's bypass.
      S_SCAN: begin
        if (addr_q == LAST_ADDR) begin
          state_d  = S_RESULT;
          busy_d   = 1'b0;
          rvalid_d = 1'b1;
          rclass_d = best_idx;
          rlogit_d = best_val;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_RESULT: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d    = S_IDLE;
        busy_d     = 1'b0;
        l2_start_d = 1'b0;
      end
    endcase

`ifdef INFER_TIMEOUT_EN
    err_d   = 1'b0;
    watched = (state_q == S_L1_RUN) || (state_q == S_L2_RUN) || (state_q == S_L2_RELEASE);
    // A handshake arriving on the final allowed cycle still wins over the abort.
    if (watched && (state_d == state_q) && (cnt_q >= CNT_LIMIT)) begin
      state_d    = S_IDLE;
      busy_d     = 1'b0;
      l2_start_d = 1'b0;
      err_d      = 1'b1;
    end
    if (!watched || (state_d != state_q)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      l1_start_q <= 1'b0;
      l2_start_q <= 1'b0;
      addr_q     <= '0;
      rvalid_q   <= 1'b0;
      rclass_q   <= '0;
      rlogit_q   <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      l1_start_q <= l1_start_d;
      l2_start_q <= l2_start_d;
      addr_q     <= addr_d;
      rvalid_q   <= rvalid_d;
      rclass_q   <= rclass_d;
      rlogit_q   <= rlogit_d;
    end
  end

`ifdef INFER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy         = busy_q;
  assign l1_start     = l1_start_q;
  assign l2_start     = l2_start_q;
  assign l2_read_addr = addr_q;
  assign result_valid = rvalid_q;
  assign result_class = rclass_q;
  assign result_logit = rlogit_q;

endmodule
